adder_driver: RTL and testbench
===============================

ADDER_DRIVER -- requirements
Module: adder_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, sum and count width.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, giving the cycles held in SETTLE (range 1..255).
REQ-003 The block SHALL have parameter RUN_CYCLES, default 16, giving the cycles held in RUN (range 1..255).
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port wb_rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port active, input, 1 bit: project enable; low aborts and idles the block.
REQ-007 The block SHALL have port cmd_valid, input, 1 bit, and port cmd_ready, output, 1 bit: the command handshake.
REQ-008 The block SHALL have ports cmd_a and cmd_b, inputs, WIDTH bits each: the operands.
REQ-009 The block SHALL have ports drv_a and drv_b, outputs, WIDTH bits each: the operands driven to the instrumented adder.
REQ-010 The block SHALL have port drv_clear, output, 1 bit: clear pulse to the adder's chain counter.
REQ-011 The block SHALL have port drv_run, output, 1 bit: enables the instrumented chain.
REQ-012 The block SHALL have ports adder_sum and chain_count, inputs, WIDTH bits each: the adder result and the chain counter.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the response handshake.
REQ-014 The block SHALL have ports rsp_sum and rsp_count, outputs, WIDTH bits each: the captured sum and count.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: set when the captured sum does not match the expected sum.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SETTLE, RUN, CAPTURE and RESP.
REQ-017 cmd_ready SHALL equal active AND (state == IDLE); a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-018 On accept, the block SHALL register cmd_a and cmd_b into drv_a and drv_b and SHALL go to LOAD.
REQ-019 drv_a and drv_b SHALL hold their value until the next accept.
REQ-020 LOAD SHALL last 1 cycle with drv_clear=1, then go to SETTLE.
REQ-021 SETTLE SHALL last SETTLE_CYCLES cycles, counted by an internal 8-bit down-counter.
REQ-022 RUN SHALL last RUN_CYCLES cycles with the registered run bit set.
REQ-023 drv_run SHALL equal the registered run bit AND active, and so drops in the same cycle active falls.
REQ-024 CAPTURE SHALL last 1 cycle and SHALL register adder_sum into rsp_sum and chain_count into rsp_count.
REQ-025 RESP SHALL hold rsp_valid=1 with the rsp_* outputs stable until rsp_ready=1, then go to IDLE.
REQ-026 rsp_valid SHALL first be high SETTLE_CYCLES+RUN_CYCLES+2 edges after the accepting edge (22 at defaults).
REQ-027 A new command SHALL NOT be accepted in the cycle the response completes; the earliest next accept is the following cycle.
REQ-028 The expected sum SHALL be (cmd_a + cmd_b) mod 2^WIDTH, with the carry out discarded.
REQ-029 active low in any non-IDLE state SHALL force IDLE on the next edge, clear the run bit, drop rsp_valid and discard the response.
REQ-030 Any abort per REQ-029 SHALL leave drv_a, drv_b, rsp_sum and rsp_count unchanged.
REQ-031 cmd_valid SHALL be ignored outside IDLE, and rsp_ready SHALL be ignored outside RESP.

Reset
REQ-032 Asserting wb_rst_n low SHALL force, asynchronously, state=IDLE and all counters 0.
REQ-033 While wb_rst_n is low, all outputs SHALL be 0, except cmd_ready which SHALL be 0 while in reset.
REQ-034 After reset release, cmd_ready SHALL equal active.
REQ-035 A reset asserted mid-operation SHALL abandon the operation with no response.

Configuration
REQ-036 With macro ADDER_DRIVER_CHECK_EN defined, the block SHALL register the expected sum at accept and SHALL set rsp_err in CAPTURE when adder_sum differs from it.
REQ-037 With ADDER_DRIVER_CHECK_EN undefined, rsp_err SHALL be tied to 0 and no expected-sum register SHALL exist.

Verification
REQ-038 Defaults, cmd_a=0x0000_0003, cmd_b=0x0000_0005, adder returns 8 and count 0x40 -> rsp_valid 22 edges after accept, with rsp_sum=8, rsp_count=0x40 and rsp_err=0.
REQ-039 cmd_a=0xFFFF_FFFF, cmd_b=1, adder returns 0 -> rsp_sum=0 and rsp_err=0 (wrap); adder returns 1 -> rsp_err=1 with CHECK_EN and 0 without.
REQ-040 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_* stable and cmd_ready=0 throughout; rsp_ready=1 -> IDLE next edge, cmd_ready=1.
REQ-041 Drop active during RUN -> drv_run=0 in the same cycle, IDLE next edge, no rsp_valid, and drv_a/drv_b unchanged.
REQ-042 Assert wb_rst_n low during SETTLE with no clock edge -> all outputs 0 immediately; after release, a new command completes normally.
REQ-043 Issue back-to-back commands with cmd_valid held high -> the second command is accepted exactly one cycle after the first response's handshake.

Source files
------------

// File: rtl/adder_driver.sv
// adder_driver: sequences one operand pair through an instrumented adder.
// A command loads drv_a/drv_b, pulses drv_clear, lets the adder settle,
// enables the chain for a fixed window, then captures the sum and the chain
// count and returns them on a ready/valid response.
// Optional build macro: ADDER_DRIVER_CHECK_EN registers the expected sum at
// accept and flags rsp_err when the captured adder_sum disagrees with it.
module adder_driver #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned RUN_CYCLES    = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             active,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] drv_a,
   output logic [WIDTH-1:0] drv_b,
   output logic             drv_clear,
   output logic             drv_run,
   input  logic [WIDTH-1:0] adder_sum,
   input  logic [WIDTH-1:0] chain_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic [WIDTH-1:0] rsp_count,
   output logic             rsp_err
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_RUN     = 3'd3;
   localparam logic [2:0] ST_CAPTURE = 3'd4;
   localparam logic [2:0] ST_RESP    = 3'd5;

   // The counter is preloaded with N-1 so a state lasts exactly N cycles.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] RUN_LOAD    = 8'(RUN_CYCLES - 1);

   logic [2:0] state;
   logic [7:0] cnt;
   logic       run_q;
   logic       accept;
   logic       capture;

   // cmd_ready is gated by reset so it reads 0 while reset is held.
   assign cmd_ready = active && wb_rst_n && (state == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign capture   = active && (state == ST_CAPTURE);
   assign drv_clear = (state == ST_LOAD);
   assign drv_run   = run_q && active;
   assign rsp_valid = (state == ST_RESP);

   // Control FSM: dropping active aborts from any state back to IDLE.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         run_q <= 1'b0;
      end else if (!active) begin
         state <= ST_IDLE;
         cnt   <= '0;
         run_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) state <= ST_LOAD;
            end
            ST_LOAD: begin
               state <= ST_SETTLE;
               cnt   <= SETTLE_LOAD;
            end
            ST_SETTLE: begin
               if (cnt == 8'd0) begin
                  state <= ST_RUN;
                  cnt   <= RUN_LOAD;
                  run_q <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_RUN: begin
               if (cnt == 8'd0) begin
                  state <= ST_CAPTURE;
                  run_q <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ST_CAPTURE: begin
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               run_q <= 1'b0;
            end
         endcase
      end
   end

   // Operand and result registers: loaded only on accept / non-aborted capture.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         drv_a     <= '0;
         drv_b     <= '0;
         rsp_sum   <= '0;
         rsp_count <= '0;
      end else begin
         if (accept) begin
            drv_a <= cmd_a;
            drv_b <= cmd_b;
         end
         if (capture) begin
            rsp_sum   <= adder_sum;
            rsp_count <= chain_count;
         end
      end
   end

`ifdef ADDER_DRIVER_CHECK_EN
   logic [WIDTH-1:0] exp_sum;

   // Expected sum is taken at accept (carry dropped) and compared at capture.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         exp_sum <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (accept)  exp_sum <= cmd_a + cmd_b;
         if (capture) rsp_err <= (adder_sum != exp_sum);
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_driver.sv
// tb_adder_driver: directed-vector bench for adder_driver at default parameters.
// The adder is modelled by driving adder_sum/chain_count with fixed values.
module tb_adder_driver;

   localparam int unsigned W = 32;

`ifdef ADDER_DRIVER_CHECK_EN
   localparam logic EXP_BAD_ERR = 1'b1;
`else
   localparam logic EXP_BAD_ERR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         active;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [W-1:0] cmd_a, cmd_b;
   logic [W-1:0] drv_a, drv_b;
   logic         drv_clear, drv_run;
   logic [W-1:0] adder_sum, chain_count;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_sum, rsp_count;
   logic         rsp_err;

   int n_vec  = 0;
   int n_miss = 0;

   adder_driver #(
      .WIDTH         (32),
      .SETTLE_CYCLES (4),
      .RUN_CYCLES    (16)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_n    (rst_n),
      .active      (active),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .drv_a       (drv_a),
      .drv_b       (drv_b),
      .drv_clear   (drv_clear),
      .drv_run     (drv_run),
      .adder_sum   (adder_sum),
      .chain_count (chain_count),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_sum     (rsp_sum),
      .rsp_count   (rsp_count),
      .rsp_err     (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a command and return #1 after the accepting edge.
   task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
      check("accept_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Count edges from the accept until rsp_valid, and cycles with drv_run high.
   task automatic wait_rsp(output int lat, output int runs);
      lat  = 0;
      runs = 0;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (drv_run) runs++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("hs_valid_low", rsp_valid, 0);
      check("hs_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      int lat, runs, seen;
      rst_n       = 1'b0;
      active      = 1'b1;
      cmd_valid   = 1'b0;
      cmd_a       = '0;
      cmd_b       = '0;
      rsp_ready   = 1'b0;
      adder_sum   = '0;
      chain_count = '0;

      // Reset state
      #3;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_drv_clear", drv_clear, 0);
      check("rst_drv_run", drv_run, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", cmd_ready, 1);
      active = 1'b0;
      #1;
      check("inactive_ready", cmd_ready, 0);
      active = 1'b1;

      // Basic 3 + 5
      adder_sum   = 32'd8;
      chain_count = 32'h40;
      send_cmd(32'h3, 32'h5);
      check("load_clear", drv_clear, 1);
      check("load_ready", cmd_ready, 0);
      check("drv_a", drv_a, 32'h3);
      check("drv_b", drv_b, 32'h5);
      wait_rsp(lat, runs);
      check("latency", lat, 22);
      check("run_cycles", runs, 16);
      check("sum", rsp_sum, 32'd8);
      check("count", rsp_count, 32'h40);
      check("err", rsp_err, 0);
      handshake();

      // Wrap: adder correct
      adder_sum   = 32'h0;
      chain_count = 32'h21;
      send_cmd(32'hFFFF_FFFF, 32'h1);
      wait_rsp(lat, runs);
      check("wrap_latency", lat, 22);
      check("wrap_sum", rsp_sum, 32'h0);
      check("wrap_err", rsp_err, 0);
      handshake();

      // Wrap: adder wrong
      adder_sum = 32'h1;
      send_cmd(32'hFFFF_FFFF, 32'h1);
      wait_rsp(lat, runs);
      check("bad_sum", rsp_sum, 32'h1);
      check("bad_err", rsp_err, EXP_BAD_ERR);
      handshake();

      // Backpressure: hold RESP for 10 cycles
      adder_sum   = 32'h1234_6789;
      chain_count = 32'h99;
      send_cmd(32'h1234_5678, 32'h0000_1111);
      wait_rsp(lat, runs);
      adder_sum   = 32'hDEAD_BEEF;
      chain_count = 32'h5555;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", rsp_valid, 1);
         check("hold_sum", rsp_sum, 32'h1234_6789);
         check("hold_count", rsp_count, 32'h99);
         check("hold_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      handshake();

      // Abort by dropping active during RUN
      send_cmd(32'h11, 32'h22);
      for (int i = 0; i < 40 && !drv_run; i++) begin
         @(posedge clk);
         #1;
      end
      check("abort_run_on", drv_run, 1);
      active = 1'b0;
      #1;
      check("abort_run_off", drv_run, 0);
      @(posedge clk);
      #1;
      active = 1'b1;
      #1;
      check("abort_idle", cmd_ready, 1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen++;
      end
      check("abort_no_rsp", seen, 0);
      check("abort_drv_a", drv_a, 32'h11);
      check("abort_drv_b", drv_b, 32'h22);
      check("abort_sum", rsp_sum, 32'h1234_6789);
      check("abort_count", rsp_count, 32'h99);

      // Asynchronous reset during SETTLE
      send_cmd(32'hA5A5_0000, 32'h0000_5A5A);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_drv_a", drv_a, 0);
      check("arst_drv_b", drv_b, 0);
      check("arst_sum", rsp_sum, 0);
      check("arst_count", rsp_count, 0);
      check("arst_valid", rsp_valid, 0);
      check("arst_ready", cmd_ready, 0);
      check("arst_err", rsp_err, 0);
      check("arst_clear", drv_clear, 0);
      @(negedge clk);
      rst_n       = 1'b1;
      adder_sum   = 32'hA5A5_5A5A;
      chain_count = 32'h7;
      send_cmd(32'hA5A5_0000, 32'h0000_5A5A);
      wait_rsp(lat, runs);
      check("arst_re_latency", lat, 22);
      check("arst_re_sum", rsp_sum, 32'hA5A5_5A5A);
      check("arst_re_count", rsp_count, 32'h7);
      handshake();

      // Back-to-back commands with cmd_valid held high
      adder_sum   = 32'h300;
      chain_count = 32'h10;
      send_cmd(32'h100, 32'h200);
      cmd_valid = 1'b1;
      cmd_a     = 32'hBEEF;
      cmd_b     = 32'h1;
      wait_rsp(lat, runs);
      check("b2b_lat1", lat, 22);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("b2b_hs_valid", rsp_valid, 0);
      check("b2b_no_early", drv_a, 32'h100);
      check("b2b_ready", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("b2b_accept_a", drv_a, 32'hBEEF);
      check("b2b_load", drv_clear, 1);
      adder_sum = 32'hBEF0;
      wait_rsp(lat, runs);
      check("b2b_lat2", lat, 22);
      check("b2b_sum2", rsp_sum, 32'hBEF0);
      handshake();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
